// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle stack-return controller.
// Stages, instruction types, function codes and ALU opcodes.
package ctrl_pkg;

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID    = 3'd1;
  localparam logic [2:0] S_EX    = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_ST    = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [1:0] T_R = 2'b00;
  localparam logic [1:0] T_J = 2'b01;
  localparam logic [1:0] T_I = 2'b10;
  localparam logic [1:0] T_S = 2'b11;

  localparam logic [31:0] R_AND = 32'd0;
  localparam logic [31:0] R_ADD = 32'd1;
  localparam logic [31:0] R_SUB = 32'd2;
  localparam logic [31:0] R_CMP = 32'd3;
  localparam logic [31:0] R_OR  = 32'd4;
  localparam logic [31:0] R_XOR = 32'd5;

  localparam logic [31:0] J_J   = 32'd0;
  localparam logic [31:0] J_JAL = 32'd1;

  localparam logic [31:0] I_ANDI = 32'd0;
  localparam logic [31:0] I_ADDI = 32'd1;
  localparam logic [31:0] I_LW   = 32'd2;
  localparam logic [31:0] I_SW   = 32'd3;
  localparam logic [31:0] I_BEQ  = 32'd4;

  localparam logic [31:0] SH_SLL  = 32'd0;
  localparam logic [31:0] SH_SLR  = 32'd1;
  localparam logic [31:0] SH_SLLV = 32'd2;
  localparam logic [31:0] SH_SLRV = 32'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SLR = 4'd6;

  function automatic logic func_legal(
    input logic [1:0]  t,
    input logic [31:0] f
  );
    logic ok;
    ok = 1'b0;
    case (t)
      T_R:     ok = (f <= R_XOR);
      T_J:     ok = (f <= J_JAL);
      T_I:     ok = (f <= I_BEQ);
      default: ok = (f <= SH_SLRV);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_stack_ptr.sv
// ctrl_stack_ptr: return-stack occupancy counter.
// Refuses to move past empty or full and reports the attempt.
module ctrl_stack_ptr
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  output logic [SP_W-1:0] sp,
  output logic            ovf,
  output logic            unf
);

  assign ovf = push && (sp == SP_W'(DEPTH));
  assign unf = pop && (sp == '0);

  // count legal pushes and pops; blocked moves leave sp alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !ovf) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !unf) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: stage sequencer and strobe decoder for the stack datapath.
// Define CTRL_MEM_WAIT_EN to hold MEM until mem_ready is seen.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int FUNC_W      = 5,
  parameter int ALUOP_W     = 4,
  parameter int STACK_DEPTH = 16,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         inst_type,
  input  logic [FUNC_W-1:0]  inst_function,
  input  logic               stop_bit,
  input  logic               zero_flag,
  input  logic               mem_ready,
  output logic [2:0]         state,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               pc_add_src1,
  output logic               pc_add_src2,
  output logic               ext_src,
  output logic               ext_sign,
  output logic               rs2_src,
  output logic               alu_src,
  output logic               wb_en,
  output logic               wb_data_sel,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               st_rd,
  output logic               st_wr,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [SP_W-1:0]    sp,
  output logic               fault
);

  logic [2:0]  state_q;
  logic [2:0]  nxt;
  logic [31:0] fn;
  logic [3:0]  aop;
  logic is_r, is_j, is_i, is_s, legal;
  logic op_j, op_jal, op_cmp, op_beq, op_lw, op_sw;
  logic op_and, op_add, op_sub, op_or, op_xor;
  logic op_sll, op_slr, sh_imm;
  logic act, push, pop, ovf, unf, mem_done;

  assign fn   = 32'(inst_function);
  assign is_r = (inst_type == T_R);
  assign is_j = (inst_type == T_J);
  assign is_i = (inst_type == T_I);
  assign is_s = (inst_type == T_S);
  assign legal = func_legal(inst_type, fn);

  assign op_j   = is_j & (fn == J_J);
  assign op_jal = is_j & (fn == J_JAL);
  assign op_cmp = is_r & (fn == R_CMP);
  assign op_beq = is_i & (fn == I_BEQ);
  assign op_lw  = is_i & (fn == I_LW);
  assign op_sw  = is_i & (fn == I_SW);

  assign op_and = (is_r & (fn == R_AND)) | (is_i & (fn == I_ANDI));
  assign op_add = (is_r & (fn == R_ADD))
                | (is_i & (fn == I_ADDI)) | op_lw | op_sw;
  assign op_sub = (is_r & (fn == R_SUB)) | op_cmp | op_beq;
  assign op_or  = is_r & (fn == R_OR);
  assign op_xor = is_r & (fn == R_XOR);
  assign op_sll = is_s & ((fn == SH_SLL) | (fn == SH_SLLV));
  assign op_slr = is_s & ((fn == SH_SLR) | (fn == SH_SLRV));
  assign sh_imm = is_s & ((fn == SH_SLL) | (fn == SH_SLR));

`ifdef CTRL_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif

  assign push = (state_q == S_ST) & op_jal;
  assign pop  = (state_q == S_ST) & ~op_jal;

  ctrl_stack_ptr #(
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_stack_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .sp    (sp),
    .ovf   (ovf),
    .unf   (unf)
  );

  // stage sequencing; a stop bit diverts the return to IF through ST
  always_comb begin
    nxt = state_q;
    unique case (state_q)
      S_IF:  nxt = S_ID;
      S_ID: begin
        if (!legal)      nxt = S_FAULT;
        else if (op_j)   nxt = S_IF;
        else if (op_jal) nxt = S_ST;
        else             nxt = S_EX;
      end
      S_EX: begin
        if (op_cmp | op_beq)    nxt = S_IF;
        else if (op_lw | op_sw) nxt = S_MEM;
        else                    nxt = S_WB;
      end
      S_MEM: begin
        if (!mem_done)  nxt = S_MEM;
        else if (op_lw) nxt = S_WB;
        else            nxt = S_IF;
      end
      S_WB:    nxt = S_IF;
      S_ST:    nxt = (ovf | unf) ? S_FAULT : S_IF;
      default: nxt = S_FAULT;
    endcase
    if (nxt == S_IF && state_q != S_ST && stop_bit && !op_jal) begin
      nxt = S_ST;
    end
  end

  // stage register, FAULT is held until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= nxt;
  end

  // ALU opcode for the decoded instruction
  always_comb begin
    aop = ALU_ADD;
    unique case (1'b1)
      op_and:  aop = ALU_AND;
      op_add:  aop = ALU_ADD;
      op_sub:  aop = ALU_SUB;
      op_or:   aop = ALU_OR;
      op_xor:  aop = ALU_XOR;
      op_sll:  aop = ALU_SLL;
      op_slr:  aop = ALU_SLR;
      default: aop = ALU_ADD;
    endcase
  end

  // next-PC source: stack top after a pop, adder for taken jumps
  always_comb begin
    pc_src = 2'd0;
    if (act) begin
      if (state_q == S_ST && !op_jal)
        pc_src = 2'd0;
      else if (op_j | op_jal | (op_beq & zero_flag))
        pc_src = 2'd1;
      else
        pc_src = 2'd2;
    end
  end

  assign state = state_q;
  assign act   = (state_q != S_IF) && (state_q != S_FAULT);
  assign fault = (state_q == S_FAULT);
  assign ir_we = (state_q == S_IF);
  assign pc_we = (nxt == S_IF);

  assign pc_add_src1 = act & op_beq;
  assign pc_add_src2 = act & op_beq;
  assign ext_src     = act & is_i;
  assign ext_sign    = act & is_i;
  assign rs2_src     = act & op_sw;
  assign alu_src     = act & (is_i | sh_imm);
  assign wb_data_sel = act & op_lw;
  assign alu_op      = act ? ALUOP_W'(aop) : '0;

  assign wb_en  = (state_q == S_WB);
  assign mem_rd = (state_q == S_MEM) & op_lw;
  assign mem_wr = (state_q == S_MEM) & op_sw;
  assign st_wr  = push & ~ovf;
  assign st_rd  = pop & ~unf;

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Clocked, parametrised multi-cycle control unit for the 16-bit stack-return datapath. It holds the stage register (IF/ID/EX/MEM/WB/ST), decodes `inst_type`/`inst_function` into datapath strobes, and tracks the return-address stack pointer internally. It flags stack overflow and underflow through a sticky fault state. It sits between the instruction register and the datapath and replaces the previous combinational, state-fed controller.

## Interface
- `FUNC_W`, 5: instruction function field width.
- `ALUOP_W`, 4: ALU opcode width.
- `STACK_DEPTH`, 16: return-stack entries; `SP_W = $clog2(STACK_DEPTH+1)`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inst_type` in 2: R=00, J=01, I=10, S=11.
- `inst_function` in FUNC_W: function code.
- `stop_bit` in 1: return-after-instruction flag.
- `zero_flag` in 1: ALU zero, valid in EX.
- `mem_ready` in 1: data-memory completion.
- `state` out 3: current stage.
- `ir_we`, `pc_we` out 1: IR load, PC load.
- `pc_src` out 2: 0 = stack top, 1 = target adder, 2 = PC+1.
- `pc_add_src1`, `pc_add_src2` out 1: 1 = BEQ offset, 0 = jump offset.
- `ext_src`, `ext_sign`, `rs2_src`, `alu_src`, `wb_en`, `wb_data_sel`, `mem_rd`, `mem_wr`, `st_rd`, `st_wr` out 1: datapath strobes.
- `alu_op` out ALUOP_W: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SLR6.
- `sp` out SP_W: stack occupancy.
- `fault` out 1: sticky overflow, underflow or illegal instruction.

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, ST=5, FAULT=6.
- IF→ID always. `ir_we`=1 in IF only.
- ID transitions:
  - J (func 0) → IF, or → ST if `stop_bit`.
  - JAL (func 1) → ST.
  - Undefined codes → FAULT.
  - Everything else → EX.
- EX transitions:
  - CMP (R/3) and BEQ (I/4) → IF.
  - LW (I/2) and SW (I/3) → MEM.
  - Other R, I and S codes → WB.
- MEM: LW → WB, SW → IF.
- WB → IF. ST → IF.
- Any transition to IF from a state other than ST, with `stop_bit`=1 and not JAL, goes to ST instead (return pop).
- ST behaviour:
  - JAL: `st_wr`=1, `sp`+1.
  - Otherwise: `st_rd`=1, `sp`−1.
  - Push with `sp`==STACK_DEPTH, or pop with `sp`==0: FAULT, no `sp` change, no `pc_we`.
- `pc_we`=1 in the final cycle of each instruction, i.e. the cycle whose next state is IF.
- `pc_src` selection:
  - 0 after a pop.
  - 1 for J, for JAL, and for BEQ with `zero_flag`=1.
  - 2 otherwise.
- `pc_add_src1`/`pc_add_src2` = 1 for BEQ, 0 otherwise.
- `wb_en` only in WB. `mem_rd`/`mem_wr` only in MEM, for LW/SW.
- `wb_data_sel`=1 only for LW.
- `rs2_src`=1 only for SW.
- `ext_src`/`ext_sign` = 1 for I-type, 0 otherwise.
- `alu_src`=1 for I-type and SLL/SLR.
- `alu_op` mapping: AND/ANDI→AND, ADD/ADDI/LW/SW→ADD, SUB/CMP/BEQ→SUB, SLL/SLLV→SLL, SLR/SLRV→SLR.
- FAULT is absorbing until reset: all strobes 0, `fault`=1.

## Timing
- Reset values: `state`=IF, `sp`=0, `fault`=0. All strobes are decoded from the registered state, so `ir_we`=1 and every other strobe is 0 during reset.
- Outputs are combinational from `state` and instruction fields. `state` and `sp` update on the rising clock edge.
- Cycles per instruction, without stop: J 2; CMP/BEQ 3; JAL 3; R/S ALU 4; SW 4; LW 5. A stop-return adds 1.
- `zero_flag` is sampled combinationally in the BEQ EX cycle.
- Reset asserted mid-instruction returns to IF immediately. Stack contents are not preserved; `sp`=0.

## Configuration
- `CTRL_MEM_WAIT_EN` defined: MEM holds while `mem_ready`=0. `mem_rd`/`mem_wr` stay asserted for the whole wait, and exit happens in the cycle after `mem_ready`=1 is seen.
- Undefined: MEM always lasts 1 cycle and `mem_ready` is ignored. The port is still present.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - inst_type constants;
  - function codes for each type;
  - ALU opcode constants.
- Sub-module `ctrl_stack_ptr` is a saturating-checked up/down counter. Inputs: push, pop, DEPTH. Outputs: `sp`, `ovf`, `unf`.

## Test plan
- Reset then R/ADD (00/1), stop=0 → states IF,ID,EX,WB,IF; `alu_op`=0; `wb_en` only in cycle 4; `pc_src`=2.
- BEQ (10/4), `zero_flag`=1 → 3 cycles; `pc_src`=1 with `pc_add_src1`=1 on the final cycle. Repeat with `zero_flag`=0 → `pc_src`=2.
- JAL ×STACK_DEPTH → `sp`=16. The 17th JAL → FAULT with `fault`=1 and `sp` held.
- JAL then ADD with stop=1 → ST cycle with `st_rd`=1, `pc_src`=0, `sp` back to 0. Stop on an empty stack → FAULT.
- LW with `CTRL_MEM_WAIT_EN` and `mem_ready` low for 3 cycles → MEM lasts 4 cycles, `mem_rd` held, then WB with `wb_data_sel`=1.
- `rst_n` pulsed low during EX of SW → asynchronous return to IF, `mem_wr` never asserted, `sp`=0.
